// File: rtl/bs_pkg.sv
// Shared definitions for the program sequencer: instruction width,
// opcode constants and the sequencer state encoding.
package bs_pkg;

    localparam int INSTR_W = 3;

    // Opcode space of the 3-bit instruction word. OP_NOP is also the value
    // presented to the processor whenever no instruction is in flight.
    localparam logic [INSTR_W-1:0] OP_NOP   = 3'b000;
    localparam logic [INSTR_W-1:0] OP_LOAD  = 3'b001;
    localparam logic [INSTR_W-1:0] OP_STORE = 3'b010;
    localparam logic [INSTR_W-1:0] OP_ADD   = 3'b011;
    localparam logic [INSTR_W-1:0] OP_SUB   = 3'b100;
    localparam logic [INSTR_W-1:0] OP_AND   = 3'b101;
    localparam logic [INSTR_W-1:0] OP_OR    = 3'b110;
    localparam logic [INSTR_W-1:0] OP_JUMP  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage : bs_pkg

// File: rtl/program_rom.sv
// Program memory: synchronous write port plus a registered read port.
// The read register has a synchronous clear so the instruction output is a
// clean flop that reads OP_NOP whenever nothing is being executed. The
// storage array itself is never reset, so a program survives a reset.
module program_rom
    import bs_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic [AW-1:0]      i_raddr,
    input  logic               i_rclr,
    output logic [INSTR_W-1:0] o_rdata
);

    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [INSTR_W-1:0] r_rdata;

    // Program store write; contents are deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read, forced to OP_NOP while the sequencer is not busy.
    always_ff @(posedge i_clk) begin
        if (i_rclr) begin
            r_rdata <= OP_NOP;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : program_rom

// File: rtl/program_sequencer.sv
// Program sequencer: steps through a small loaded program, issuing one
// instruction at a time and waiting for the processor's completion pulse,
// with a per-instruction watchdog, graceful halt and sticky error.
module program_sequencer
    import bs_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 32,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load_en,
    input  logic [AW-1:0]      i_load_addr,
    input  logic [INSTR_W-1:0] i_load_data,
    input  logic [AW-1:0]      i_last_addr,
    input  logic               i_run,
    input  logic               i_halt,
    input  logic               i_clr_err,
    input  logic               i_con_pcincr,
    output logic [INSTR_W-1:0] o_data_instruction,
    output logic               o_start,
    output logic [AW-1:0]      o_pc,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    localparam int            CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_TO = CW'(TIMEOUT - 1);
    localparam logic [AW-1:0] PC_MAX = AW'(DEPTH - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_nxt;
    logic [AW-1:0] w_pc_inc;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_start;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          w_busy_nxt;
    logic          w_rom_we;
    logic          w_rom_clr;

    // Next program counter with explicit wrap for non-power-of-two depths.
    assign w_pc_inc = (r_pc == PC_MAX) ? {AW{1'b0}} : (r_pc + AW'(1));

    // Next-state, next-pc and watchdog counter decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_run && !i_load_en && !r_err) begin
                    w_state_nxt = ST_ISSUE;
                    w_pc_nxt    = {AW{1'b0}};
                    w_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = {CW{1'b0}};
            end
            ST_WAIT: begin
                // Completion beats the watchdog when both land together.
                if (i_con_pcincr) begin
                    w_cnt_nxt = {CW{1'b0}};
                    if (r_pc == i_last_addr) begin
                        w_state_nxt = ST_DONE;
                    end else if (i_halt) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                        w_pc_nxt    = w_pc_inc;
                    end
                end else if (r_cnt == CNT_TO) begin
                    w_state_nxt = ST_ERR;
                    w_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_DONE: begin
                if (!i_run) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_ERR: begin
                if (i_clr_err) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ERR;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_busy_nxt = (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_WAIT);

    // Program loads are accepted only while the sequencer sits in IDLE.
    assign w_rom_we  = i_load_en && (r_state == ST_IDLE) && !i_rst;
    // The ROM read register follows the next pc, so the instruction is
    // already registered on the cycle ISSUE begins and stays put in WAIT.
    assign w_rom_clr = i_rst || !w_busy_nxt;

    // State, pc, watchdog and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_pc    <= {AW{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_start <= (w_state_nxt == ST_ISSUE);
            r_busy  <= w_busy_nxt;
            r_done  <= (w_state_nxt == ST_DONE);
            r_err   <= (w_state_nxt == ST_ERR);
        end
    end

    program_rom #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rom (
        .i_clk   (i_clk),
        .i_we    (w_rom_we),
        .i_waddr (i_load_addr),
        .i_wdata (i_load_data),
        .i_raddr (w_pc_nxt),
        .i_rclr  (w_rom_clr),
        .o_rdata (o_data_instruction)
    );

    assign o_start = r_start;
    assign o_pc    = r_pc;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_err   = r_err;

endmodule : program_sequencer
